// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read/write/allocate/clear requests plus registered
// read data, scoreboard status and ready.
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            i_re;
  logic            i_wr;
  logic [AW-1:0]   i_rs1;
  logic [AW-1:0]   i_rs2;
  logic [AW-1:0]   i_rd;
  logic [XLEN-1:0] i_write_data;
  logic            i_alloc;
  logic [AW-1:0]   i_alloc_rd;
  logic            i_clear;
  logic [XLEN-1:0] o_read_data1;
  logic [XLEN-1:0] o_read_data2;
  logic            o_rs1_busy;
  logic            o_rs2_busy;
  logic            o_ready;

  modport master (
    output i_re, i_wr, i_rs1, i_rs2, i_rd, i_write_data, i_alloc, i_alloc_rd, i_clear,
    input  o_read_data1, o_read_data2, o_rs1_busy, o_rs2_busy, o_ready
  );

  modport slave (
    input  i_re, i_wr, i_rs1, i_rs2, i_rd, i_write_data, i_alloc, i_alloc_rd, i_clear,
    output o_read_data1, o_read_data2, o_rs1_busy, o_rs2_busy, o_ready
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with per-register busy scoreboard and a
// zeroing sweep that runs after reset or on request.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {SWEEP, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic            active;
  logic            do_wr, do_alloc, do_rd;
  logic [XLEN-1:0] rdata1, rdata2;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    active    = 1'b0;
    case (state)
      SWEEP: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = READY;
          idx_nxt   = FIRST_IDX;
        end
      end
      READY: begin
        if (bus.i_clear) begin
          state_nxt = SWEEP;
          idx_nxt   = FIRST_IDX;
        end else begin
          active = 1'b1;
        end
      end
      default: begin
        state_nxt = SWEEP;
        idx_nxt   = FIRST_IDX;
      end
    endcase
  end

  assign do_wr    = active && bus.i_wr && (bus.i_rd != '0);
  assign do_alloc = active && bus.i_alloc && (bus.i_alloc_rd != '0);
  assign do_rd    = active && bus.i_re;
  assign bus.o_ready = (state == READY);

  // Allocate is applied after write-clear so it wins on a shared address.
  always_comb begin
    busy_nxt = busy;
    if (state == READY && bus.i_clear) busy_nxt = '0;
    if (do_wr)    busy_nxt[bus.i_rd]       = 1'b0;
    if (do_alloc) busy_nxt[bus.i_alloc_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Register 0 is never stored; it is forced to zero on the read path.
  always_comb begin
    rdata1 = (bus.i_rs1 == '0) ? '0 : regs[bus.i_rs1];
    rdata2 = (bus.i_rs2 == '0) ? '0 : regs[bus.i_rs2];
    if (BYPASS && do_wr && (bus.i_rd == bus.i_rs1)) rdata1 = bus.i_write_data;
    if (BYPASS && do_wr && (bus.i_rd == bus.i_rs2)) rdata2 = bus.i_write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= SWEEP;
      idx              <= FIRST_IDX;
      busy             <= '0;
      bus.o_read_data1 <= '0;
      bus.o_read_data2 <= '0;
      bus.o_rs1_busy   <= 1'b0;
      bus.o_rs2_busy   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
      if (do_rd) begin
        bus.o_read_data1 <= rdata1;
        bus.o_read_data2 <= rdata2;
        bus.o_rs1_busy   <= busy_nxt[bus.i_rs1];
        bus.o_rs2_busy   <= busy_nxt[bus.i_rs2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      regs[idx] <= '0;
    end else if (do_wr) begin
      regs[bus.i_rd] <= bus.i_write_data;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: BYPASS=1 and BYPASS=0 instances share stimulus and are
// checked against a behavioural array/counter model plus a directed vector table.
module tb_reg_file_sb;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          re, wr, alloc, clr;
  logic [AW-1:0] rs1, rs2, rd, ard;
  logic [XL-1:0] wd;

  reg_file_sb_if #(.XLEN(XL), .AW(AW)) ifa ();
  reg_file_sb_if #(.XLEN(XL), .AW(AW)) ifn ();

  assign ifa.i_re = re;          assign ifn.i_re = re;
  assign ifa.i_wr = wr;          assign ifn.i_wr = wr;
  assign ifa.i_rs1 = rs1;        assign ifn.i_rs1 = rs1;
  assign ifa.i_rs2 = rs2;        assign ifn.i_rs2 = rs2;
  assign ifa.i_rd = rd;          assign ifn.i_rd = rd;
  assign ifa.i_write_data = wd;  assign ifn.i_write_data = wd;
  assign ifa.i_alloc = alloc;    assign ifn.i_alloc = alloc;
  assign ifa.i_alloc_rd = ard;   assign ifn.i_alloc_rd = ard;
  assign ifa.i_clear = clr;      assign ifn.i_clear = clr;

  reg_file_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  reg_file_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(ifn));

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, busy set, and cycles left before ready.
  logic [XL-1:0] m_mem [NR];
  bit   [NR-1:0] m_busy;
  bit            m_ready;
  int            m_left;
  logic [XL-1:0] m_d1a, m_d2a, m_d1n, m_d2n;
  bit            m_b1, m_b2;

  task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_enter_sweep();
    m_ready = 1'b0;
    m_left  = NR - 1;
    m_busy  = '0;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
  endtask

  task automatic model_reset();
    model_enter_sweep();
    m_d1a = '0; m_d2a = '0; m_d1n = '0; m_d2n = '0;
    m_b1 = 1'b0; m_b2 = 1'b0;
  endtask

  task automatic model_step();
    logic [XL-1:0] old [NR];
    if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (clr) begin
      model_enter_sweep();
    end else begin
      old = m_mem;
      if (wr && rd != 0) begin
        m_mem[rd]  = wd;
        m_busy[rd] = 1'b0;
      end
      if (alloc && ard != 0) m_busy[ard] = 1'b1;
      if (re) begin
        m_d1a = m_mem[rs1]; m_d2a = m_mem[rs2];
        m_d1n = old[rs1];   m_d2n = old[rs2];
        m_b1  = m_busy[rs1]; m_b2 = m_busy[rs2];
      end
    end
  endtask

  task automatic compare_all();
    chk("ready_a", ifa.o_ready, m_ready);
    chk("ready_n", ifn.o_ready, m_ready);
    chk("d1_a", ifa.o_read_data1, m_d1a);
    chk("d2_a", ifa.o_read_data2, m_d2a);
    chk("d1_n", ifn.o_read_data1, m_d1n);
    chk("d2_n", ifn.o_read_data2, m_d2n);
    chk("b1_a", ifa.o_rs1_busy, m_b1);
    chk("b2_a", ifa.o_rs2_busy, m_b2);
    chk("b1_n", ifn.o_rs1_busy, m_b1);
    chk("b2_n", ifn.o_rs2_busy, m_b2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    re = 0; wr = 0; alloc = 0; clr = 0;
    rs1 = '0; rs2 = '0; rd = '0; ard = '0; wd = '0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int k = 0; k < NR; k++) begin
      idle();
      re = 1; rs1 = AW'(k); rs2 = AW'(NR - 1 - k);
      tick();
      chk({tag, "_d1"}, ifa.o_read_data1, '0);
      chk({tag, "_d2"}, ifn.o_read_data2, '0);
      chk({tag, "_b1"}, ifa.o_rs1_busy, '0);
    end
    idle();
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 1; i <= NR - 1; i++) begin
      tick();
      chk(tag, ifa.o_ready, (i == NR - 1) ? 1 : 0);
    end
  endtask

  typedef struct {
    logic          re, wr;
    logic [AW-1:0] rs1, rs2, rd;
    logic [XL-1:0] wd;
    logic          alloc;
    logic [AW-1:0] ard;
    logic [XL-1:0] d1, d2, d1n, d2n;
    logic          b1, b2;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 1, 0, 0, 5, 32'hABCDEFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 7, 32'hABCDADFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 5, 7, 0, 0, 0, 0, 32'hABCDEFFF, 32'hABCDADFF, 32'hABCDEFFF, 32'hABCDADFF, 0, 0};
    tbl[3]  = '{1, 1, 5, 7, 5, 32'h12345678, 0, 0, 32'h12345678, 32'hABCDADFF, 32'hABCDEFFF, 32'hABCDADFF, 0, 0};
    tbl[4]  = '{1, 0, 5, 5, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 5, 9, 0, 0, 0, 0, 32'h12345678, 0, 32'h12345678, 0, 0, 1};
    tbl[9]  = '{1, 1, 5, 9, 9, 32'h1, 0, 0, 32'h12345678, 32'h1, 32'h12345678, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 9, 9, 32'h2, 1, 9, 0, 32'h2, 0, 32'h1, 0, 1};
    tbl[11] = '{1, 0, 9, 9, 0, 0, 0, 0, 32'h2, 32'h2, 32'h2, 32'h2, 1, 1};

    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 0;
    wait_ready("ready_after_reset");
    read_all_zero("init_read");

    foreach (tbl[i]) begin
      re = tbl[i].re; wr = tbl[i].wr; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      rd = tbl[i].rd; wd = tbl[i].wd; alloc = tbl[i].alloc; ard = tbl[i].ard; clr = 0;
      tick();
      chk($sformatf("vec%0d_d1", i), ifa.o_read_data1, tbl[i].d1);
      chk($sformatf("vec%0d_d2", i), ifa.o_read_data2, tbl[i].d2);
      chk($sformatf("vec%0d_d1n", i), ifn.o_read_data1, tbl[i].d1n);
      chk($sformatf("vec%0d_d2n", i), ifn.o_read_data2, tbl[i].d2n);
      chk($sformatf("vec%0d_b1", i), ifa.o_rs1_busy, tbl[i].b1);
      chk($sformatf("vec%0d_b2", i), ifa.o_rs2_busy, tbl[i].b2);
    end

    // Clear in READY, then hammer writes/allocs/reads during the sweep.
    idle();
    clr = 1;
    tick();
    for (int i = 1; i <= NR - 1; i++) begin
      idle();
      wr = 1; rd = 3; wd = $urandom; re = 1; rs1 = 9; rs2 = 3; alloc = 1; ard = 4; clr = 1;
      tick();
      chk("ready_after_clear", ifa.o_ready, (i == NR - 1) ? 1 : 0);
      chk("sweep_hold_d1", ifa.o_read_data1, 32'h2);
    end
    read_all_zero("post_clear");

    // Asynchronous reset mid-operation with non-zero outputs.
    idle();
    wr = 1; rd = 6; wd = 32'hDEADBEEF; alloc = 1; ard = 6; re = 1; rs1 = 6; rs2 = 6;
    tick();
    chk("pre_rst_b1", ifa.o_rs1_busy, 1);
    idle();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 0;
    repeat (7) tick();
    #2 rst = 1;
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    wait_ready("ready_after_midsweep_rst");
    read_all_zero("post_rst");

    for (int n = 0; n < 800; n++) begin
      re    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      alloc = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 79) == 0);
      rs1   = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      rs2   = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      rd    = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      ard   = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      wd    = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, at least 4; AW = log2(NREGS).
REQ-003 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write array contents.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_re  in  1  read enable, both read ports.
REQ-007 i_wr  in  1  write enable.
REQ-008 i_rs1, i_rs2  in  AW  read addresses.
REQ-009 i_rd  in  AW  write address.
REQ-010 i_write_data  in  XLEN  write data.
REQ-011 i_alloc  in  1  scoreboard allocate strobe.
REQ-012 i_alloc_rd  in  AW  register being allocated (marked pending).
REQ-013 i_clear  in  1  start register-clear sweep.
REQ-014 o_read_data1, o_read_data2  out  XLEN  registered read data.
REQ-015 o_rs1_busy, o_rs2_busy  out  1  registered scoreboard status of read addresses.
REQ-016 o_ready  out  1  block accepting reads, writes and allocates.

Function
REQ-017 State machine has two states: SWEEP and READY; o_ready = 1 only in READY.
REQ-018 SWEEP: a sweep index starts at 1; each cycle writes 0 to register[index] and increments index; after writing index NREGS-1, next state is READY (sweep lasts NREGS-1 cycles).
REQ-019 READY with i_clear=1: next state SWEEP, index=1, all busy bits cleared; the remaining inputs that cycle are ignored.
REQ-020 In SWEEP, i_re, i_wr, i_alloc and i_clear are ignored; outputs o_read_data* and o_rs*_busy hold.
REQ-021 Register 0 reads as 0 always; writes and allocates to address 0 are discarded; busy[0] is always 0.
REQ-022 Write: in READY with i_wr=1 and i_rd!=0, register[i_rd] takes i_write_data at the edge and busy[i_rd] is cleared.
REQ-023 Allocate: in READY with i_alloc=1 and i_alloc_rd!=0, busy[i_alloc_rd] is set; allocate wins over write-clear on the same address in the same cycle (data is still written).
REQ-024 Read: in READY with i_re=1, o_read_dataN updates at the edge with register[i_rsN]; latency 1 cycle; with i_re=0, outputs hold.
REQ-025 BYPASS=1: if i_wr=1, i_rd=i_rsN and i_rd!=0 in the read cycle, o_read_dataN takes i_write_data; BYPASS=0: it takes the old contents.
REQ-026 With i_re=1, o_rsN_busy takes the post-update busy bit of i_rsN (after REQ-022 and REQ-023 are applied), independent of BYPASS.
REQ-027 The two read ports are independent; the same address on both ports returns identical data.

Reset
REQ-028 While rst=1: state=SWEEP, index=1, all busy bits 0, o_read_data1/2=0, o_rs1/2_busy=0, o_ready=0; the array is not reset directly.
REQ-029 After rst deasserts, the sweep runs (REQ-018); o_ready rises NREGS-1 cycles after the first rising edge with rst=0.
REQ-030 rst asserted mid-sweep or mid-operation aborts immediately and restarts the sweep from index 1 after release.

Verification
REQ-031 Reset, NREGS=32 -> o_ready=0 for 31 edges then 1; read of every register returns 0.
REQ-032 Write reg5=32'hABCDEFFF, then reg7=32'hABCDADFF; next cycle i_re, rs1=5, rs2=7 -> after 1 edge o_read_data1=ABCDEFFF, o_read_data2=ABCDADFF.
REQ-033 Same cycle i_wr, rd=5, data 32'h12345678, i_re, rs1=5 -> BYPASS=1: 12345678; BYPASS=0: ABCDEFFF; following read returns 12345678 in both cases.
REQ-034 Write rd=0 with data 32'hFFFFFFFF, alloc rd=0, then read rs1=0 -> data 0, busy 0.
REQ-035 Alloc rd=9; read rs2=9 -> busy 1; write rd=9 data 32'h1 with i_re rs2=9 -> busy 0, data 1 (BYPASS=1); alloc rd=9 and write rd=9 same cycle -> busy 1.
REQ-036 Assert i_clear in READY, then i_wr during sweep -> o_ready=0 for 31 cycles, write ignored, busy bits 0, all registers read 0 after o_ready returns to 1.
